// File: rtl/oqpsk_pkg.sv
// Shared types and elaboration-time helpers for the OQPSK half-sine shaper.
package oqpsk_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // round(amp * sin(pi*k/(2*spc))) for 0 <= k <= spc; Taylor series avoids relying on $sin.
  function automatic int half_sine(int k, int spc, int amp);
    real x;
    real term;
    real s;
    x    = 3.14159265358979 * real'(k) / (2.0 * real'(spc));
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(real'(amp) * s + 0.5);
  endfunction

endpackage

// File: rtl/chip_fifo.sv
// Single-bit chip FIFO with registered count; DEPTH must be a power of two.
module chip_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   din_i,
  output logic                   dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntFull);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/oqpsk_shaper.sv
// OQPSK half-sine pulse shaper: chips alternate I/Q, Q offset by one chip period (SPC ticks).
module oqpsk_shaper
  import oqpsk_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned SPC   = 25,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AMP   = 2 ** (W - 1) - 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                chip_in,
  input  logic                chip_valid,
  output logic                chip_ready,
  input  logic                en,
  input  logic                dac_ready,
  output logic signed [W-1:0] i_out,
  output logic signed [W-1:0] q_out,
  output logic                busy,
  output logic                underrun
);

  localparam int unsigned PW = $clog2(2 * SPC);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PhQ     = PW'(SPC - 1);
  localparam logic [PW-1:0] PhMid   = PW'(SPC);
  localparam logic [PW-1:0] PhLast  = PW'(2 * SPC - 1);
  localparam logic [PW-1:0] PhTwo   = PW'(2 * SPC);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  state_e             state_q, state_d;
  logic [PW-1:0]      ph_q, ph_d, ph_next;
  logic               i_act_q, i_act_d, q_act_q, q_act_d;
  logic               i_sign_q, i_sign_d, q_sign_q, q_sign_d;
  logic               underrun_q, underrun_d;
  logic               live_q;
  logic signed [W-1:0] i_out_q, q_out_q, i_smp, q_smp;

  logic               push, pop, can_pop;
  logic               fifo_dout, fifo_empty, fifo_full;
  logic [CW-1:0]      fifo_count;

  logic [W-1:0]       rom [2**PW];
  logic [PW-1:0]      q_ph, i_k, q_k;
  logic [W-1:0]       i_mag, q_mag;

  // Quarter-period ROM; entries past SPC are never addressed.
  for (genvar g = 0; g < 2 ** PW; g++) begin : g_rom
    if (g <= SPC) begin : g_ent
      assign rom[g] = W'(half_sine(g, SPC, AMP));
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  assign chip_ready = live_q & (fifo_count < CntFull);
  assign push       = chip_valid & chip_ready & ~fifo_full;
  assign can_pop    = en & ~fifo_empty;

  chip_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (resetn),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (chip_in),
    .dout_o (fifo_dout),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    i_act_d    = i_act_q;
    q_act_d    = q_act_q;
    i_sign_d   = i_sign_q;
    q_sign_d   = q_sign_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    ph_next    = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
    if (dac_ready) begin
      case (state_q)
        StIdle: begin
          if (can_pop) begin
            pop      = 1'b1;
            i_sign_d = fifo_dout;
            i_act_d  = 1'b1;
            q_act_d  = 1'b0;
            ph_d     = '0;
            state_d  = StRun;
          end
        end
        StRun: begin
          ph_d = ph_next;
          if (ph_q == PhQ || ph_q == PhLast) begin
            if (can_pop) begin
              pop = 1'b1;
              if (ph_q == PhQ) begin
                q_sign_d = fifo_dout;
                q_act_d  = 1'b1;
              end else begin
                i_sign_d = fifo_dout;
                i_act_d  = 1'b1;
              end
            end else begin
              if (ph_q == PhQ) q_act_d = 1'b0;
              else             i_act_d = 1'b0;
              state_d    = StDrain;
              underrun_d = en;
            end
          end
        end
        StDrain: begin
          // Finish once the surviving channel reaches the end of its pulse.
          if ((i_act_q && ph_q == PhLast) || (q_act_q && ph_q == PhQ) || !(i_act_q || q_act_q)) begin
            state_d = StIdle;
            ph_d    = '0;
            i_act_d = 1'b0;
            q_act_d = 1'b0;
          end else begin
            ph_d = ph_next;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Samples are taken from the phase selected by this tick.
  always_comb begin
    q_ph  = (ph_d >= PhMid) ? ph_d - PhMid : ph_d + PhMid;
    i_k   = (ph_d <= PhMid) ? ph_d : PhTwo - ph_d;
    q_k   = (q_ph <= PhMid) ? q_ph : PhTwo - q_ph;
    i_mag = rom[i_k];
    q_mag = rom[q_k];
    i_smp = '0;
    q_smp = '0;
    if (i_act_d) i_smp = i_sign_d ? $signed(i_mag) : -$signed(i_mag);
    if (q_act_d) q_smp = q_sign_d ? $signed(q_mag) : -$signed(q_mag);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      i_act_q    <= 1'b0;
      q_act_q    <= 1'b0;
      i_sign_q   <= 1'b0;
      q_sign_q   <= 1'b0;
      underrun_q <= 1'b0;
      live_q     <= 1'b0;
      i_out_q    <= '0;
      q_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      i_act_q    <= i_act_d;
      q_act_q    <= q_act_d;
      i_sign_q   <= i_sign_d;
      q_sign_q   <= q_sign_d;
      underrun_q <= underrun_d;
      live_q     <= 1'b1;
      if (dac_ready) begin
        i_out_q <= i_smp;
        q_out_q <= q_smp;
      end
    end
  end

  assign i_out    = i_out_q;
  assign q_out    = q_out_q;
  assign busy     = (state_q != StIdle);
  assign underrun = underrun_q;

endmodule

// File: doc/oqpsk_shaper.md
OQPSK_SHAPER -- requirements
Module: oqpsk_shaper

Interface
REQ-001 SHALL have parameter W, default 4: signed sample width of i_out/q_out.
REQ-002 SHALL have parameter SPC, default 25: DAC samples per chip period Tc; each half-sine pulse spans 2*SPC samples.
REQ-003 SHALL have parameter DEPTH, default 4: chip FIFO depth, power of two, >=2.
REQ-004 SHALL have parameter AMP, default 2**(W-1)-1: peak pulse amplitude.
REQ-005 SHALL have port clk  in  1  system clock, 50 MHz.
REQ-006 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port chip_in  in  1  chip value; 1 = positive pulse, 0 = negative pulse.
REQ-008 SHALL have port chip_valid  in  1  chip_in is valid.
REQ-009 SHALL have port chip_ready  out  1  FIFO accepts a chip this cycle.
REQ-010 SHALL have port en  in  1  transmit enable; gates starting and continuing a burst.
REQ-011 SHALL have port dac_ready  in  1  sample tick; the DAC consumes one sample per cycle in which it is high.
REQ-012 SHALL have port i_out  out  W  signed I sample.
REQ-013 SHALL have port q_out  out  W  signed Q sample.
REQ-014 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-015 SHALL have port underrun  out  1  one-cycle pulse when a chip is needed and the FIFO is empty.

Function
REQ-016 SHALL push chip_in into the FIFO when chip_valid and chip_ready are both high.
REQ-017 SHALL drive chip_ready = (FIFO count < DEPTH), combinational from the registered count; a pop in the same cycle does not raise it.
REQ-018 SHALL run an FSM with states IDLE, RUN and DRAIN.
REQ-019 SHALL advance phase counter ph (0..2*SPC-1, wraps to 0) only on tick = dac_ready in RUN/DRAIN.
REQ-020 SHALL go IDLE->RUN on a tick with en=1 and FIFO non-empty: pop chip to I sign, activate I, set ph=0; Q stays inactive.
REQ-021 SHALL, in RUN on a tick at ph==SPC-1 (Q) or ph==2*SPC-1 (I), pop the next chip into that channel's sign if en=1 and FIFO non-empty; chips therefore alternate I, Q, I, Q.
REQ-022 SHALL, in RUN when a pop is due but the FIFO is empty or en=0, deactivate that channel, go to DRAIN, and pulse underrun only if en=1.
REQ-023 SHALL, in DRAIN, perform no pops and enter IDLE at the other channel's next pop point; ph resets to 0 and both channels are inactive.
REQ-024 SHALL compute the I magnitude as rom[k] with k = ph for ph<=SPC, else 2*SPC-ph; Q uses the same with phase (ph+SPC) mod 2*SPC; rom[k] = round(AMP*sin(pi*k/(2*SPC))), so rom[0]=0 and rom[SPC]=AMP.
REQ-025 SHALL output +mag for sign 1, -mag for sign 0, and 0 for an inactive channel; no overflow is possible because AMP <= 2**(W-1)-1.
REQ-026 SHALL register i_out/q_out; they update one clk after the tick that selects their phase and hold when dac_ready=0.
REQ-027 SHALL hold FIFO contents in IDLE when en=0.

Reset
REQ-028 SHALL, while resetn=0 at a clk edge, clear the FIFO, set state IDLE and ph=0, and drive i_out=0, q_out=0, busy=0, underrun=0 and chip_ready=0.
REQ-029 SHALL raise chip_ready the first cycle after reset release; reset mid-burst aborts without draining.

Structure
REQ-030 SHALL place the state enum typedef and a constant function that builds the half-sine ROM (SPC+1 entries) in package oqpsk_pkg.
REQ-031 SHALL instantiate the FIFO as sub-module chip_fifo (parameter DEPTH, push/pop/count/empty/full).

Verification
REQ-032 SHALL verify reset: resetn=0 for 5 cycles -> i_out=q_out=0, chip_ready=0; release -> chip_ready=1 next cycle.
REQ-033 SHALL verify shape: W=4, SPC=25, chips 1,0,1,0 preloaded, en=1, dac_ready=1 -> i_out peaks +7 at ph=25, q_out peaks -7 at ph=0 of the second period, and |i_out|+|q_out| > 0 after Q starts.
REQ-034 SHALL verify stall: dac_ready=0 for 10 cycles mid-pulse -> i_out/q_out/ph frozen, and the waveform resumes without skipping a sample.
REQ-035 SHALL verify underrun: push 3 chips only -> one underrun pulse at the 4th pop point, DRAIN until I's pulse ends, then IDLE with outputs 0.
REQ-036 SHALL verify full FIFO: DEPTH=4, en=0, offer 5 chips -> 4 accepted, chip_ready=0 after the 4th, 5th stalls until the first pop.
REQ-037 SHALL verify reset mid-burst: resetn=0 during RUN at ph=12 -> next cycle IDLE, FIFO empty, outputs 0.
